// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci regfile fill sequencer.
package fib_pkg;

  localparam int unsigned ADDR_W_DEF   = 6;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned FIB_BASE_IDX = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage : fib_pkg

// File: rtl/fib_seq_ctrl.sv
// Fills regfile entries 2..last_addr with mem[i] = mem[i-2] + mem[i-1],
// reading operands one per cycle through the regfile's single read port.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_wen
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(FIB_BASE_IDX);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [ADDR_W-1:0] lim, lim_next;
  logic [DATA_W-1:0] a, a_next;
  logic [DATA_W-1:0] b, b_next;
  logic              ovf_next;
  logic [DATA_W:0]   sum;

  // Write port is held at idx / A+B in every state; only rf_wen qualifies it.
  assign sum      = (DATA_W+1)'(a) + (DATA_W+1)'(b);
  assign rf_waddr = idx;
  assign rf_wdata = sum[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= BASE;
      lim   <= '0;
      a     <= '0;
      b     <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      lim   <= lim_next;
      a     <= a_next;
      b     <= b_next;
      ovf   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    lim_next   = lim;
    a_next     = a;
    b_next     = b;
    ovf_next   = ovf;
    busy       = 1'b0;
    done       = 1'b0;
    rf_wen     = 1'b0;
    rf_raddr   = '0;

    case (state)
      IDLE: begin
        if (start) begin
          lim_next   = last_addr;
          idx_next   = BASE;
          ovf_next   = 1'b0;
          state_next = (last_addr >= BASE) ? RD_A : DONE;
        end
      end
      RD_A: begin
        busy       = 1'b1;
        rf_raddr   = idx - BASE;
        a_next     = rf_rdata;
        state_next = RD_B;
      end
      RD_B: begin
        busy       = 1'b1;
        rf_raddr   = idx - ONE;
        b_next     = rf_rdata;
        state_next = WR;
      end
      WR: begin
        busy     = 1'b1;
        rf_wen   = 1'b1;
        ovf_next = ovf | sum[DATA_W];
        // Compare before incrementing so idx never wraps at the top entry.
        if (idx == lim) begin
          state_next = DONE;
        end else begin
          idx_next   = idx + ONE;
          state_next = RD_A;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule : fib_seq_ctrl

// File: tb/tb_fib_seq_ctrl.sv
// Scoreboard bench for fib_seq_ctrl with a behavioural single-port regfile.
module tb_fib_seq_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] last_addr;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_wen;

  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];
  logic          seed_we;
  logic [AW-1:0] seed_addr;
  logic [DW-1:0] seed_data;

  logic [AW+DW-1:0] sb_q[$];
  logic [AW+DW-1:0] sb_e;

  int n_cmp;
  int n_err;

  fib_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_addr (last_addr),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_wen    (rf_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: combinational read, one write port shared with seeding.
  assign rf_rdata = mem[rf_raddr];
  always @(posedge clk) begin
    if (seed_we) mem[seed_addr] <= seed_data;
    else if (rf_wen) mem[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write the DUT makes must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && rf_wen) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wen", 64'(1), 64'(0));
      end else begin
        sb_e = sb_q.pop_front();
        check("waddr", 64'(rf_waddr), 64'(sb_e[AW+DW-1:DW]));
        check("wdata", 64'(rf_wdata), 64'(sb_e[DW-1:0]));
      end
    end
  end

  task automatic seed(input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    seed_we   = 1'b1;
    seed_addr = AW'(addr);
    seed_data = data;
    @(posedge clk);
    #1;
    seed_we = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic run_fill(input int l, input bit hold);
    int busy_cnt;
    int done_cyc;
    bit exp_ovf;
    logic [DW:0] s;
    exp_ovf = 1'b0;
    for (int i = 2; i <= l; i++) begin
      s = {1'b0, ref_mem[i-2]} + {1'b0, ref_mem[i-1]};
      ref_mem[i] = s[DW-1:0];
      exp_ovf |= s[DW];
      sb_q.push_back({AW'(i), s[DW-1:0]});
    end
    @(negedge clk);
    start     = 1'b1;
    last_addr = AW'(l);
    @(posedge clk);
    #1;
    if (hold) last_addr = AW'(l) ^ 6'h2a;
    else start = 1'b0;
    busy_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("ovf_cleared", 64'(ovf), 64'(0));
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        start    = 1'b0;
      end
    end
    check("done_cycle", 64'(done_cyc), 64'((l >= 2) ? 3*(l-1)+1 : 1));
    check("busy_cycles", 64'(busy_cnt), 64'((l >= 2) ? 3*(l-1) : 0));
    check("ovf_at_done", 64'(ovf), 64'(exp_ovf));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));
    @(negedge clk);
    check("no_refill", 64'(busy), 64'(0));
    check("ovf_held", 64'(ovf), 64'(exp_ovf));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    last_addr = '0;
    seed_we   = 1'b0;
    seed_addr = '0;
    seed_data = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_wen", 64'(rf_wen), 64'(0));
    check("rst_raddr", 64'(rf_raddr), 64'(0));
    check("rst_waddr", 64'(rf_waddr), 64'(2));
    rst = 1'b0;
    for (int i = 0; i < 64; i++) seed(i, 32'hdead_0000 | DW'(i));

    // Basic fill 2..7 from seeds 2,2
    seed(0, 32'd2);
    seed(1, 32'd2);
    run_fill(7, 1'b0);
    check("mem7", 64'(mem[7]), 64'(42));

    // Degenerate lengths: no writes at all
    run_fill(1, 1'b0);
    run_fill(0, 1'b0);

    // Carry-out and its clearing on the next start
    seed(0, 32'h8000_0000);
    seed(1, 32'h8000_0000);
    run_fill(2, 1'b0);
    check("mem2_wrap", 64'(mem[2]), 64'(0));
    check("ovf_set", 64'(ovf), 64'(1));
    seed(0, 32'd1);
    seed(1, 32'd1);
    run_fill(2, 1'b0);

    // start held and last_addr disturbed mid-fill
    seed(0, 32'd3);
    seed(1, 32'd5);
    run_fill(5, 1'b1);

    // Reset during RD_B of idx=4
    seed(0, 32'd2);
    seed(1, 32'd2);
    seed(4, 32'hdead_beef);
    ref_mem[2] = 32'd4;
    ref_mem[3] = 32'd6;
    sb_q.push_back({AW'(2), 32'd4});
    sb_q.push_back({AW'(3), 32'd6});
    @(negedge clk);
    start     = 1'b1;
    last_addr = AW'(10);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_wen", 64'(rf_wen), 64'(0));
    check("arst_raddr", 64'(rf_raddr), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    check("rst_mem2", 64'(mem[2]), 64'(4));
    check("rst_mem3", 64'(mem[3]), 64'(6));
    check("rst_mem4", 64'(mem[4]), 64'(32'hdead_beef));
    check("rst_sb", 64'(sb_q.size()), 64'(0));
    run_fill(10, 1'b0);

    // Full-depth fill: top entry reached without wrap
    seed(0, 32'd1);
    seed(1, 32'd1);
    run_fill(63, 1'b0);
    check("mem63_fib64", 64'(mem[63]), 64'(32'd1640636603));
    check("ovf_full", 64'(ovf), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fib_seq_ctrl
